// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: NUM_REQ producers share one FIFO write port through
// a registered write stage, with a bounded burst lock per owner.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  data_in,
    output logic [NUM_REQ-1:0]         gnt,
    input  logic                       fifo_full,
    input  logic                       fifo_afull,
    output logic                       fifo_wr,
    output logic [DATA_W-1:0]          fifo_data,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy
);
    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam logic [7:0]       MAX_CNT  = 8'(MAX_BURST);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    // Handshake: producer i holds req[i] and its data slice until an edge with
    // req[i] && gnt[i]; that edge is the transfer. gnt never feeds back into req.
    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [7:0]         burst_cnt_q, burst_cnt_d;
    logic               fifo_wr_q, fifo_wr_d;
    logic [DATA_W-1:0]  fifo_data_q, fifo_data_d;

    logic               stall;
    logic               lock;
    logic               found;
    logic               grant;
    logic [IDX_W-1:0]   win;
    int                 cand;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    endfunction

    // The afull term blocks a grant while an in-flight write takes the last slot.
    assign stall = fifo_full || (fifo_afull && fifo_wr_q);

    always_comb begin
        lock  = (state_q == BURST) && req[owner_q] && (burst_cnt_q < MAX_CNT);
        found = 1'b0;
        win   = owner_q;
        cand  = 0;
        if (lock) begin
            found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = (int'(rr_ptr_q) + k) % NUM_REQ;
                if (!found && req[cand]) begin
                    found = 1'b1;
                    win   = IDX_W'(cand);
                end
            end
        end
        grant = found && !stall;
        gnt   = '0;
        if (grant) begin
            gnt[win] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        fifo_wr_d   = 1'b0;
        fifo_data_d = fifo_data_q;
        if (grant) begin
            fifo_wr_d   = 1'b1;
            fifo_data_d = data_in[int'(win)*DATA_W +: DATA_W];
            if (state_q == BURST && win == owner_q) begin
                burst_cnt_d = burst_cnt_q + 8'd1;
            end else begin
                // A new winner while in BURST means the old owner dropped its request.
                if (state_q == BURST) begin
                    rr_ptr_d = next_idx(owner_q);
                end
                owner_d     = win;
                burst_cnt_d = 8'd1;
                state_d     = BURST;
            end
            if (burst_cnt_d == MAX_CNT) begin
                rr_ptr_d = next_idx(win);
                state_d  = IDLE;
            end
        end else if (state_q == BURST && !req[owner_q]) begin
            rr_ptr_d = next_idx(owner_q);
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            fifo_wr_q   <= 1'b0;
            fifo_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_data_q <= fifo_data_d;
        end
    end

    assign fifo_wr   = fifo_wr_q;
    assign fifo_data = fifo_data_q;
    assign owner     = owner_q;
    assign busy      = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: burst/round-robin ordering, stalls, reset,
// plus a FIFO-side scoreboard for per-producer data integrity.
module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, gnt;
    logic [31:0] data_in;
    logic        full, afull, wr;
    logic [7:0]  fdata;
    logic [1:0]  owner;
    logic        busy;
    logic [3:0]  req1, gnt1;
    logic        full1, afull1, wr1;
    logic [7:0]  fdata1;
    logic [1:0]  owner1;
    logic        busy1;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    int          seq[4];
    logic        pend[4];
    int          fcount, received, j;
    logic        wr_now, pop, done;
    logic [7:0]  d_now;
    logic [3:0]  acc;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) u_dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .gnt(gnt),
        .fifo_full(full), .fifo_afull(afull), .fifo_wr(wr), .fifo_data(fdata),
        .owner(owner), .busy(busy)
    );

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(1)) u_rr (
        .clk(clk), .rst(rst), .req(req1), .data_in(data_in), .gnt(gnt1),
        .fifo_full(full1), .fifo_afull(afull1), .fifo_wr(wr1), .fifo_data(fdata1),
        .owner(owner1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic grant_step(input string tag, input logic [3:0] eg, input logic [7:0] ed);
        #1;
        check({tag, "_gnt"}, gnt, eg);
        tick();
        check({tag, "_wr"}, wr, 1);
        check({tag, "_data"}, fdata, ed);
    endtask

    task automatic rr_step(input string tag, input logic [3:0] eg, input logic [7:0] ed);
        #1;
        check({tag, "_gnt"}, gnt1, eg);
        tick();
        check({tag, "_wr"}, wr1, 1);
        check({tag, "_data"}, fdata1, ed);
    endtask

    initial begin
        rst = 1'b0; req = '0; req1 = '0; full = 1'b0; afull = 1'b0;
        full1 = 1'b0; afull1 = 1'b0;
        data_in = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        #1 rst = 1'b1;
        #2;
        check("reset_wr", wr, 0);
        check("reset_data", fdata, 0);
        check("reset_busy", busy, 0);
        check("reset_owner", owner, 0);
        tick();
        rst = 1'b0;

        // MAX_BURST=1 instance: step rr_ptr to 3, then all request -> 3,0,1,2,3
        req1 = 4'b0100;
        rr_step("wrap_pre", 4'b0100, 8'hA2);
        req1 = 4'b1111;
        rr_step("wrap0", 4'b1000, 8'hA3);
        rr_step("wrap1", 4'b0001, 8'hA0);
        rr_step("wrap2", 4'b0010, 8'hA1);
        rr_step("wrap3", 4'b0100, 8'hA2);
        rr_step("wrap4", 4'b1000, 8'hA3);
        req1 = '0;

        // Burst rotation, MAX_BURST=4: 0,0,0,0,1,1,1,1,0 with no bubble
        req = 4'b0011;
        for (int k = 0; k < 4; k++) grant_step("rot_a", 4'b0001, 8'hA0);
        for (int k = 0; k < 4; k++) grant_step("rot_b", 4'b0010, 8'hA1);
        grant_step("rot_c", 4'b0001, 8'hA0);
        check("rot_owner", owner, 0);
        req = '0;
        #1;
        check("idle_gnt", gnt, 0);
        tick();
        check("idle_wr", wr, 0);
        check("idle_busy", busy, 0);

        // Owner drop: owner 0 leaves after 2 words, req[3] takes over without a bubble
        req = 4'b0001;
        grant_step("drop_pre", 4'b0001, 8'hA0);
        grant_step("drop_pre", 4'b0001, 8'hA0);
        req = 4'b1000;
        grant_step("drop", 4'b1000, 8'hA3);
        check("drop_owner", owner, 3);
        check("drop_busy", busy, 1);
        // rr_ptr must now be 1: searching from 1 picks producer 1, not 0
        req = 4'b0011;
        grant_step("drop_rr", 4'b0010, 8'hA1);
        check("drop_rr_owner", owner, 1);

        // Back-pressure with owner 1 holding burst_cnt=1
        afull = 1'b1;
        #1;
        check("afull_gnt", gnt, 0);
        tick();
        check("afull_wr", wr, 0);
        afull = 1'b0;
        full  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("full_gnt", gnt, 0);
            tick();
            check("full_wr", wr, 0);
            check("full_owner", owner, 1);
            check("full_busy", busy, 1);
        end
        full = 1'b0;
        for (int k = 0; k < 3; k++) grant_step("resume", 4'b0010, 8'hA1);
        grant_step("resume_rot", 4'b0001, 8'hA0);
        req = '0;
        tick();
        check("all_idle_wr", wr, 0);
        check("all_idle_busy", busy, 0);

        // Reset mid-burst with owner 2, burst_cnt 3
        req = 4'b0100;
        for (int k = 0; k < 3; k++) grant_step("pre_rst", 4'b0100, 8'hA2);
        check("pre_rst_owner", owner, 2);
        #2;
        rst = 1'b1;
        #1;
        check("rst_wr", wr, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_data", fdata, 0);
        tick();
        rst = 1'b0;
        grant_step("rst_first", 4'b0100, 8'hA2);
        check("rst_first_owner", owner, 2);
        req = 4'b0101;
        for (int k = 0; k < 3; k++) grant_step("rst_cnt", 4'b0100, 8'hA2);
        grant_step("rst_rot", 4'b0001, 8'hA0);
        req = '0;
        tick();
        tick();

        // Data integrity: 4 producers x 16 words {i,seq} into a depth-4 FIFO model
        fcount = 0; received = 0; acc = '0; done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seq[i]  = 0;
            pend[i] = 1'b0;
        end
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            wr_now = wr;
            d_now  = fdata;
            if (wr_now) begin
                check("no_write_full", 32'(fcount < 4), 1);
                j = -1;
                foreach (exp_q[k]) if (j < 0 && exp_q[k][7:4] == d_now[7:4]) j = k;
                check("sb_found", 32'(j >= 0), 1);
                if (j >= 0) begin
                    check("sb_order", d_now, exp_q[j]);
                    exp_q.delete(j);
                    received++;
                end
            end
            pop = (fcount > 0) && ($urandom_range(0, 2) == 0);
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    pend[i] = 1'b0;
                    seq[i]++;
                end
                if (!pend[i] && seq[i] < 16 && $urandom_range(0, 3) != 0) begin
                    pend[i] = 1'b1;
                    exp_q.push_back({4'(i), 4'(seq[i])});
                    data_in[i*8 +: 8] = {4'(i), 4'(seq[i])};
                end
                req[i] = pend[i];
            end
            full  = (fcount == 4);
            afull = (fcount == 3);
            #1;
            check("gnt_onehot", 32'($onehot0(gnt)), 1);
            acc = gnt & req;
            tick();
            fcount = fcount + (wr_now ? 1 : 0) - (pop ? 1 : 0);
            done = (received == 64);
        end
        check("sb_received", received, 64);
        check("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter sharing one FIFO write port among `NUM_REQ` producers. Each cycle it selects at most one requesting producer, accepts its word with a valid/ready handshake, and forwards it to the FIFO through a registered write stage. A bounded burst lock lets a producer stream up to `MAX_BURST` consecutive words before priority rotates. The block sits directly in front of the shared FIFO's write side and guarantees the FIFO is never written while full.

## Interface

**Parameters**
- `NUM_REQ`, default 4: number of producers, range 2..16.
- `DATA_W`, default 8: word width; matches the FIFO data width.
- `MAX_BURST`, default 4: maximum consecutive grants to one owner, range 1..255.

**Ports**
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input `NUM_REQ`: per-producer request; its word is valid while high.
- `data_in` input `NUM_REQ*DATA_W`: producer words; slice i is `[i*DATA_W +: DATA_W]`.
- `gnt` output `NUM_REQ`: combinational one-hot ready; a transfer occurs on any edge where `req[i] && gnt[i]`.
- `fifo_full` input 1: FIFO full flag.
- `fifo_afull` input 1: FIFO has exactly one free slot.
- `fifo_wr` output 1: registered, active-high write strobe to the FIFO.
- `fifo_data` output `DATA_W`: registered write data.
- `owner` output `$clog2(NUM_REQ)`: index of the current burst owner; valid while `busy` is high.
- `busy` output 1: high in state BURST.

## Operation

**State.** The block holds `state` (IDLE, BURST), `rr_ptr`, `owner`, and `burst_cnt` (8 bits).

**Stall condition.** `stall = fifo_full || (fifo_afull && fifo_wr)`. The second term covers an in-flight write that will fill the last slot. While `stall` is high, `gnt` is all zero.

**Winner selection** (combinational, when not stalled):
- In BURST with `req[owner]` high and `burst_cnt < MAX_BURST`: the winner is `owner`.
- Otherwise: the winner is the first index with `req` high, searching from `rr_ptr` upward and wrapping modulo `NUM_REQ`.
- `gnt` is one-hot of the winner. It is zero if there is no winner.

**On a transfer edge** (winner w):
- `fifo_wr <= 1` and `fifo_data <= data_in` slice w.
- If w == `owner` and state is BURST: `burst_cnt <= burst_cnt + 1`.
- Otherwise: `owner <= w`, `burst_cnt <= 1`, state becomes BURST.
- If the resulting count equals `MAX_BURST`: `rr_ptr <= (w+1) mod NUM_REQ` and state becomes IDLE.

**On an edge with no transfer:**
- `fifo_wr <= 0`; `fifo_data` holds its value.
- If in BURST and `req[owner]` is low: `rr_ptr <= (owner+1) mod NUM_REQ` and state becomes IDLE.
- Owner drop with another requester present: the ending burst must not lose a cycle. In the same cycle, round-robin selection ignores the burst lock, the new winner is granted, and `rr_ptr` advances past the old owner.
- A stall in BURST holds `owner` and `burst_cnt` unchanged.

**Boundary conditions:**
- `MAX_BURST = 1`: the block degenerates to pure per-word round-robin.
- `rr_ptr` wraps from `NUM_REQ-1` to 0.
- All requesters idle: IDLE state, `fifo_wr` low.

**Reset.** Asserting `rst` immediately forces:
- `fifo_wr = 0`, `fifo_data = 0`
- state IDLE, `busy = 0`
- `rr_ptr = 0`, `owner = 0`, `burst_cnt = 0`

A burst in progress is abandoned. No partial write reaches the FIFO after reset assertion.

## Timing

- **Handshake.** A producer presents a word with `req` high. It must hold `data_in` stable until the edge where `gnt` is high, and may change the word in the cycle after. `gnt` depends combinationally on `req`, `fifo_full`, `fifo_afull` and state. There is no path from `gnt` to `req`.
- **Latency.** Accept edge N gives `fifo_wr`/`fifo_data` valid in cycle N..N+1, and the FIFO captures the word at edge N+1. Latency is 1 cycle.
- **Throughput.** One word per cycle while not stalled, including across owner changes.
- **Full handling.** The FIFO is never written while full. A full-to-not-full transition allows a grant in the same cycle.
- **Reset release.** First grant is possible in the first cycle after `rst` deasserts.

## Test plan

- **Reset mid-burst.** Assert `rst` with owner=2 and `burst_cnt=3` → asynchronously `fifo_wr=0`, `busy=0`, `owner=0`. After release, `req=0100` is granted with `burst_cnt=1`.
- **Burst rotation.** `MAX_BURST=4`; `req[0]` and `req[1]` held high, no stall → grants 0,0,0,0,1,1,1,1,0…; `fifo_wr` continuously high with no bubble.
- **Owner drop.** Owner 0 drops `req` after 2 words while `req[3]` is high → `req[3]` is granted on the next edge and `rr_ptr=1`.
- **Full back-pressure.** `fifo_afull=1` with a write in flight → `gnt=0`. Then `fifo_full=1` for 5 cycles → no `fifo_wr`; `owner` and `burst_cnt` unchanged. Release → the burst resumes from the held count.
- **Wrap-around.** `NUM_REQ=4`, `MAX_BURST=1`, all `req` high starting from `rr_ptr=3` → grant order 3,0,1,2,3.
- **Data integrity.** Each producer i sends 16 words `{i,seq}` → the FIFO-side scoreboard receives each producer's words in order, none lost or duplicated.
